// File: rtl/control_unit_pkg.sv
// Shared types for the processor control unit: state and opcode encodings,
// ALU select codes and instruction field positions.
package control_unit_pkg;

   typedef enum logic [3:0] {
      S_INIT   = 4'd0,
      S_FETCH  = 4'd1,
      S_DECODE = 4'd2,
      S_NOOP   = 4'd3,
      S_LOAD_A = 4'd4,
      S_LOAD_B = 4'd5,
      S_STORE  = 4'd6,
      S_ADD    = 4'd7,
      S_SUB    = 4'd8,
      S_HALT   = 4'd9
   } state_e;

   typedef enum logic [3:0] {
      OP_NOOP  = 4'b0000,
      OP_STORE = 4'b0001,
      OP_LOAD  = 4'b0010,
      OP_ADD   = 4'b0011,
      OP_SUB   = 4'b0100,
      OP_HALT  = 4'b0101
   } opcode_e;

   localparam logic [2:0] ALU_PASS = 3'b000;
   localparam logic [2:0] ALU_ADD  = 3'b001;
   localparam logic [2:0] ALU_SUB  = 3'b010;

   // Instruction field positions within the 16-bit IR
   localparam int OP_MSB      = 15;
   localparam int OP_LSB      = 12;
   localparam int LD_ADDR_MSB = 11;
   localparam int LD_ADDR_LSB = 4;
   localparam int ST_ADDR_MSB = 7;
   localparam int ST_ADDR_LSB = 0;
   localparam int RA_MSB      = 11;
   localparam int RA_LSB      = 8;
   localparam int RB_MSB      = 7;
   localparam int RB_LSB      = 4;
   localparam int DST_MSB     = 3;
   localparam int DST_LSB     = 0;

endpackage

// File: rtl/control_unit.sv
// Moore FSM sequencing fetch/decode/execute for the simple processor and
// decoding the instruction register into datapath controls.
module control_unit
   import control_unit_pkg::*;
#(
   parameter int DAW = 8,
   parameter int RAW = 4,
   parameter int SW  = 3
) (
   input  logic           Clk,
   input  logic           Clr,
   input  logic [15:0]    IR,
   output logic           PC_clr,
   output logic           PC_up,
   output logic           IR_ld,
   output logic [DAW-1:0] D_addr,
   output logic           D_wr,
   output logic           RF_s,
   output logic [RAW-1:0] RF_W_addr,
   output logic           RF_W_en,
   output logic [RAW-1:0] RF_Ra_addr,
   output logic [RAW-1:0] RF_Rb_addr,
   output logic [SW-1:0]  ALU_s0,
   output logic [3:0]     State
);

   state_e  state_q, state_d;
   opcode_e opcode;

   assign opcode = opcode_e'(IR[OP_MSB:OP_LSB]);
   assign State  = state_q;

   always_ff @(posedge Clk) begin
      if (Clr) state_q <= S_INIT;
      else     state_q <= state_d;
   end

   // Unassigned opcodes fall through to the NOOP path; unused state codes recover via Init
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_INIT:   state_d = S_FETCH;
         S_FETCH:  state_d = S_DECODE;
         S_DECODE: begin
            case (opcode)
               OP_STORE: state_d = S_STORE;
               OP_LOAD:  state_d = S_LOAD_A;
               OP_ADD:   state_d = S_ADD;
               OP_SUB:   state_d = S_SUB;
               OP_HALT:  state_d = S_HALT;
               default:  state_d = S_NOOP;
            endcase
         end
         S_NOOP:   state_d = S_FETCH;
         S_LOAD_A: state_d = S_LOAD_B;
         S_LOAD_B: state_d = S_FETCH;
         S_STORE:  state_d = S_FETCH;
         S_ADD:    state_d = S_FETCH;
         S_SUB:    state_d = S_FETCH;
         S_HALT:   state_d = S_HALT;
         default:  state_d = S_INIT;
      endcase
   end

   always_comb begin
      PC_clr     = 1'b0;
      PC_up      = 1'b0;
      IR_ld      = 1'b0;
      D_addr     = '0;
      D_wr       = 1'b0;
      RF_s       = 1'b0;
      RF_W_addr  = '0;
      RF_W_en    = 1'b0;
      RF_Ra_addr = '0;
      RF_Rb_addr = '0;
      ALU_s0     = SW'(ALU_PASS);
      case (state_q)
         S_INIT:  PC_clr = 1'b1;
         S_FETCH: begin
            IR_ld = 1'b1;
            PC_up = 1'b1;
         end
         // Data memory reads synchronously, so Load_A only presents the address
         S_LOAD_A, S_LOAD_B: begin
            D_addr    = DAW'(IR[LD_ADDR_MSB:LD_ADDR_LSB]);
            RF_s      = 1'b1;
            RF_W_addr = RAW'(IR[DST_MSB:DST_LSB]);
            RF_W_en   = (state_q == S_LOAD_B);
         end
         S_STORE: begin
            D_addr     = DAW'(IR[ST_ADDR_MSB:ST_ADDR_LSB]);
            RF_Ra_addr = RAW'(IR[RA_MSB:RA_LSB]);
            D_wr       = 1'b1;
         end
         S_ADD, S_SUB: begin
            RF_Ra_addr = RAW'(IR[RA_MSB:RA_LSB]);
            RF_Rb_addr = RAW'(IR[RB_MSB:RB_LSB]);
            RF_W_addr  = RAW'(IR[DST_MSB:DST_LSB]);
            RF_W_en    = 1'b1;
            ALU_s0     = (state_q == S_ADD) ? SW'(ALU_ADD) : SW'(ALU_SUB);
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_control_unit.sv
// Self-checking bench for control_unit: directed and random instruction streams
// compared cycle by cycle against a per-instruction expected-output table.
module tb_control_unit;

   // Observable outputs gathered into one record so each cycle is one comparison
   typedef struct packed {
      logic [3:0] st;
      logic       pc_clr;
      logic       pc_up;
      logic       ir_ld;
      logic [7:0] d_addr;
      logic       d_wr;
      logic       rf_s;
      logic [3:0] w_addr;
      logic       w_en;
      logic [3:0] ra;
      logic [3:0] rb;
      logic [2:0] alu;
   } obs_t;

   logic        Clk;
   logic        Clr;
   logic [15:0] IR;
   logic        PC_clr, PC_up, IR_ld, D_wr, RF_s, RF_W_en;
   logic [7:0]  D_addr;
   logic [3:0]  RF_W_addr, RF_Ra_addr, RF_Rb_addr, State;
   logic [2:0]  ALU_s0;
   obs_t        obs;

   int checks = 0;
   int passes = 0;
   obs_t exp_q[$];
   logic [15:0] prog[$];

   control_unit #(.DAW(8), .RAW(4), .SW(3)) dut (
      .Clk(Clk), .Clr(Clr), .IR(IR),
      .PC_clr(PC_clr), .PC_up(PC_up), .IR_ld(IR_ld),
      .D_addr(D_addr), .D_wr(D_wr), .RF_s(RF_s),
      .RF_W_addr(RF_W_addr), .RF_W_en(RF_W_en),
      .RF_Ra_addr(RF_Ra_addr), .RF_Rb_addr(RF_Rb_addr),
      .ALU_s0(ALU_s0), .State(State)
   );

   assign obs = {State, PC_clr, PC_up, IR_ld, D_addr, D_wr, RF_s,
                 RF_W_addr, RF_W_en, RF_Ra_addr, RF_Rb_addr, ALU_s0};

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   // Advance one clock and settle just after the edge
   task automatic step();
      @(posedge Clk);
      #1;
   endtask

   function automatic obs_t blank(input logic [3:0] st);
      obs_t o;
      o = '0;
      o.st = st;
      return o;
   endfunction

   function automatic obs_t init_rec();
      obs_t o;
      o = blank(4'd0);
      o.pc_clr = 1'b1;
      return o;
   endfunction

   function automatic obs_t fetch_rec();
      obs_t o;
      o = blank(4'd1);
      o.ir_ld = 1'b1;
      o.pc_up = 1'b1;
      return o;
   endfunction

   // Reference model: the cycle-by-cycle outputs an instruction produces,
   // built directly from the instruction-set rules
   task automatic build_seq(input logic [15:0] ins, input int halt_cycles);
      obs_t o;
      exp_q.delete();
      exp_q.push_back(fetch_rec());
      exp_q.push_back(blank(4'd2));
      case (ins[15:12])
         4'd1: begin
            o = blank(4'd6);
            o.d_addr = ins[7:0];
            o.ra     = ins[11:8];
            o.d_wr   = 1'b1;
            exp_q.push_back(o);
         end
         4'd2: begin
            o = blank(4'd4);
            o.d_addr = ins[11:4];
            o.rf_s   = 1'b1;
            o.w_addr = ins[3:0];
            exp_q.push_back(o);
            o.st   = 4'd5;
            o.w_en = 1'b1;
            exp_q.push_back(o);
         end
         4'd3, 4'd4: begin
            o = blank(ins[15:12] == 4'd3 ? 4'd7 : 4'd8);
            o.ra     = ins[11:8];
            o.rb     = ins[7:4];
            o.w_addr = ins[3:0];
            o.w_en   = 1'b1;
            o.alu    = (ins[15:12] == 4'd3) ? 3'b001 : 3'b010;
            exp_q.push_back(o);
         end
         4'd5: for (int k = 0; k < halt_cycles; k++) exp_q.push_back(blank(4'd9));
         default: exp_q.push_back(blank(4'd3));
      endcase
   endtask

   task automatic test_reset();
      Clr = 1'b1;
      IR  = 16'h0000;
      for (int i = 0; i < 2; i++) begin
         step();
         checks++;
         if (obs !== init_rec())
            $display("[TB] FAIL reset_hold%0d: got %h expected %h", i, obs, init_rec());
         else passes++;
      end
      Clr = 1'b0;
      step();
      checks++;
      if (obs !== fetch_rec()) $display("[TB] FAIL reset_fetch: got %h expected %h", obs, fetch_rec());
      else passes++;
      step();
      checks++;
      if (obs !== blank(4'd2)) $display("[TB] FAIL reset_decode: got %h expected %h", obs, blank(4'd2));
      else passes++;
      step();
      checks++;
      if (obs !== blank(4'd3)) $display("[TB] FAIL reset_noop: got %h expected %h", obs, blank(4'd3));
      else passes++;
      step();
   endtask

   // Runs every instruction in prog starting from a Fetch cycle; IR is scrambled
   // during Fetch to show it is ignored there, then set to the instruction.
   task automatic test_program();
      foreach (prog[p]) begin
         build_seq(prog[p], 0);
         IR = 16'($urandom);
         foreach (exp_q[i]) begin
            if (i > 0) step();
            if (i == 1) IR = prog[p];
            checks++;
            if (obs !== exp_q[i])
               $display("[TB] FAIL instr_%h_cyc%0d: got %h expected %h", prog[p], i, obs, exp_q[i]);
            else passes++;
            checks++;
            if ((PC_up && PC_clr) || (D_wr && RF_W_en))
               $display("[TB] FAIL exclusive_%h_cyc%0d: got %b%b%b%b expected no overlapping pair",
                        prog[p], i, PC_up, PC_clr, D_wr, RF_W_en);
            else passes++;
         end
         step();
      end
   endtask

   task automatic test_directed();
      prog.delete();
      prog.push_back(16'h2AB5);
      prog.push_back(16'h3124);
      prog.push_back(16'h4124);
      prog.push_back(16'h1C7E);
      prog.push_back(16'hF000);
      prog.push_back(16'h0000);
      test_program();
   endtask

   task automatic test_random();
      logic [15:0] ins;
      prog.delete();
      for (int n = 0; n < 80; n++) begin
         ins = 16'($urandom);
         if (ins[15:12] == 4'd5) ins[15:12] = 4'd3;
         prog.push_back(ins);
      end
      test_program();
   endtask

   task automatic test_clr_mid_load();
      IR = 16'hFFFF;
      step();
      IR = 16'h2AB5;
      checks++;
      if (State !== 4'd2) $display("[TB] FAIL midload_decode: got %0d expected 2", State);
      else passes++;
      step();
      checks++;
      if (State !== 4'd4) $display("[TB] FAIL midload_loada: got %0d expected 4", State);
      else passes++;
      Clr = 1'b1;
      step();
      checks++;
      if (obs !== init_rec()) $display("[TB] FAIL midload_clr: got %h expected %h", obs, init_rec());
      else passes++;
      Clr = 1'b0;
      step();
      checks++;
      if (obs !== fetch_rec()) $display("[TB] FAIL midload_refetch: got %h expected %h", obs, fetch_rec());
      else passes++;
   endtask

   task automatic test_halt();
      build_seq(16'h5000, 12);
      foreach (exp_q[i]) begin
         if (i > 0) step();
         if (i == 1) IR = 16'h5000;
         checks++;
         if (obs !== exp_q[i])
            $display("[TB] FAIL halt_cyc%0d: got %h expected %h", i, obs, exp_q[i]);
         else passes++;
      end
      IR = 16'h0000;
      step();
      checks++;
      if (State !== 4'd9) $display("[TB] FAIL halt_ignore_ir: got %0d expected 9", State);
      else passes++;
      Clr = 1'b1;
      step();
      checks++;
      if (obs !== init_rec()) $display("[TB] FAIL halt_clr: got %h expected %h", obs, init_rec());
      else passes++;
      Clr = 1'b0;
      step();
      checks++;
      if (obs !== fetch_rec()) $display("[TB] FAIL halt_refetch: got %h expected %h", obs, fetch_rec());
      else passes++;
   endtask

   initial begin
      Clr = 1'b1;
      IR  = 16'h0000;
      test_reset();
      test_directed();
      test_clr_mid_load();
      test_random();
      test_halt();
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
